// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 hex command/response paths: ASCII
// constants, FSM state encoding and the nibble-to-ASCII conversion.
package rs232_pkg;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_0    = 8'h30;
    localparam logic [7:0] CHAR_A_UC = 8'h41;
    localparam logic [7:0] CHAR_A_LC = 8'h61;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_LOAD = 3'd2,
        ST_HEX  = 3'd3,
        ST_CR   = 3'd4,
        ST_LF   = 3'd5
    } state_t;

    // 0-9 map to '0'-'9', 10-15 map to 'A'-'F' or 'a'-'f'
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib, input logic uppercase);
        if (nib < 4'd10)
            return CHAR_0 + {4'h0, nib};
        else
            return (uppercase ? CHAR_A_UC : CHAR_A_LC) + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/rsp_hex_encoder.sv
// Response path: pops binary words from the response FIFO and writes them
// to the TX FIFO as ASCII hex, most significant nibble first, followed by an
// optional CR/LF. Back-pressure from the TX FIFO simply holds the FSM in
// place; the character on tx_fifo_din only depends on registered state so
// it stays stable through a stall.
module rsp_hex_encoder
    import rs232_pkg::*;
#(
    parameter int P_DATA_W    = 32,
    parameter int P_EOL_CR    = 1,
    parameter int P_EOL_LF    = 1,
    parameter int P_UPPERCASE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [P_DATA_W-1:0] rsp_fifo_dout,
    input  logic                rsp_fifo_empty,
    output logic                rsp_fifo_rd_en,
    output logic [7:0]          tx_fifo_din,
    output logic                tx_fifo_wr_en,
    input  logic                tx_fifo_full,
    output logic                busy,
    output logic [15:0]         word_cnt
);

    localparam int P_NIB  = P_DATA_W / 4;
    localparam int NW     = (P_NIB > 1) ? $clog2(P_NIB) : 1;
    localparam bit HAS_CR = (P_EOL_CR != 0);
    localparam bit HAS_LF = (P_EOL_LF != 0);
    localparam bit HAS_UC = (P_UPPERCASE != 0);

    generate
        if (P_DATA_W % 4 != 0) begin : g_cfg_err
            $error("rsp_hex_encoder: P_DATA_W must be a multiple of 4");
        end
    endgenerate

    state_t                state_q;
    state_t                state_d;
    logic [P_DATA_W-1:0]   shreg;
    logic [NW-1:0]         nib_cnt;
    logic                  last_char;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state: character states only advance on an accepted write
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!rsp_fifo_empty) state_d = ST_POP;
            ST_POP:  state_d = ST_LOAD;
            ST_LOAD: state_d = ST_HEX;
            ST_HEX:
                if (tx_fifo_wr_en && nib_cnt == '0)
                    state_d = HAS_CR ? ST_CR : (HAS_LF ? ST_LF : ST_IDLE);
            ST_CR:   if (tx_fifo_wr_en) state_d = HAS_LF ? ST_LF : ST_IDLE;
            ST_LF:   if (tx_fifo_wr_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: pop strobe, character/strobe toward TX FIFO, end-of-word flag
    always_comb begin
        rsp_fifo_rd_en = 1'b0;
        tx_fifo_wr_en  = 1'b0;
        tx_fifo_din    = 8'h00;
        last_char      = 1'b0;
        busy           = (state_q != ST_IDLE);
        case (state_q)
            ST_POP: rsp_fifo_rd_en = 1'b1;
            ST_HEX: begin
                tx_fifo_wr_en = !tx_fifo_full;
                tx_fifo_din   = nib2ascii(shreg[P_DATA_W-1 -: 4], HAS_UC);
                last_char     = (nib_cnt == '0) && !HAS_CR && !HAS_LF;
            end
            ST_CR: begin
                tx_fifo_wr_en = !tx_fifo_full;
                tx_fifo_din   = CHAR_CR;
                last_char     = !HAS_LF;
            end
            ST_LF: begin
                tx_fifo_wr_en = !tx_fifo_full;
                tx_fifo_din   = CHAR_LF;
                last_char     = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: load word, shift out a nibble per accepted write, count words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            nib_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (state_q == ST_LOAD) begin
                shreg   <= rsp_fifo_dout;
                nib_cnt <= NW'(P_NIB - 1);
            end else if (state_q == ST_HEX && tx_fifo_wr_en) begin
                shreg   <= shreg << 4;
                nib_cnt <= nib_cnt - 1'b1;
            end
            if (tx_fifo_wr_en && last_char)
                word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rsp_hex_encoder.sv
// Bench for rsp_hex_encoder: three instances (defaults, lowercase, no EOL)
// fed from queue-based FIFO models; expected character streams come from
// $sformatf hex formatting of each pushed word.
module tb_rsp_hex_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dout  [3] = '{default: '0};
    logic        empty [3] = '{default: 1'b1};
    logic        full  [3] = '{default: 1'b0};
    logic        rd_en [3];
    logic        wr_en [3];
    logic        busy  [3];
    logic [7:0]  din   [3];
    logic [15:0] wcnt  [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] rq   [3][$];
    logic [7:0]  txq  [3][$];
    logic [7:0]  exq  [3][$];
    int          rcyc [3][$];
    int          wcyc [3][$];
    int          viol    [3] = '{default: 0};
    int          rd_cnt  [3] = '{default: 0};
    bit          ld_pend [3] = '{default: 1'b0};
    bit          prev_rd [3] = '{default: 1'b0};
    logic [31:0] ld_word [3] = '{default: '0};
    logic [15:0] wexp    [3] = '{default: '0};
    int          cyc = 0;

    always #5 clk = ~clk;

    rsp_hex_encoder u_def (
        .clk(clk), .rst(rst), .rsp_fifo_dout(dout[0]), .rsp_fifo_empty(empty[0]),
        .rsp_fifo_rd_en(rd_en[0]), .tx_fifo_din(din[0]), .tx_fifo_wr_en(wr_en[0]),
        .tx_fifo_full(full[0]), .busy(busy[0]), .word_cnt(wcnt[0]));

    rsp_hex_encoder #(.P_UPPERCASE(0)) u_lc (
        .clk(clk), .rst(rst), .rsp_fifo_dout(dout[1]), .rsp_fifo_empty(empty[1]),
        .rsp_fifo_rd_en(rd_en[1]), .tx_fifo_din(din[1]), .tx_fifo_wr_en(wr_en[1]),
        .tx_fifo_full(full[1]), .busy(busy[1]), .word_cnt(wcnt[1]));

    rsp_hex_encoder #(.P_EOL_CR(0), .P_EOL_LF(0)) u_ne (
        .clk(clk), .rst(rst), .rsp_fifo_dout(dout[2]), .rsp_fifo_empty(empty[2]),
        .rsp_fifo_rd_en(rd_en[2]), .tx_fifo_din(din[2]), .tx_fifo_wr_en(wr_en[2]),
        .tx_fifo_full(full[2]), .busy(busy[2]), .word_cnt(wcnt[2]));

    // Non-FWFT response FIFO models and TX FIFO capture, sampled mid-cycle.
    // dout carries the popped word only during the cycle after the pop.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (ld_pend[i]) begin
                dout[i]    = ld_word[i];
                ld_pend[i] = 1'b0;
            end else begin
                dout[i] = $urandom;
            end
            if (rd_en[i]) begin
                if (empty[i] || prev_rd[i] || rq[i].size() == 0) viol[i]++;
                else begin
                    ld_word[i] = rq[i].pop_front();
                    ld_pend[i] = 1'b1;
                end
                rd_cnt[i]++;
                rcyc[i].push_back(cyc);
            end
            prev_rd[i] = rd_en[i];
            if (wr_en[i]) begin
                if (full[i]) viol[i]++;
                txq[i].push_back(din[i]);
                wcyc[i].push_back(cyc);
            end
            empty[i] = (rq[i].size() == 0);
        end
    end

    // Instance 1 is lowercase, instance 2 has no end-of-line.
    task automatic push_word(input int i, input logic [31:0] w);
        string s;
        s = $sformatf("%08h", w);
        if (i != 1) s = s.toupper();
        if (i != 2) s = {s, "\r\n"};
        for (int k = 0; k < s.len(); k++) exq[i].push_back(s[k]);
        rq[i].push_back(w);
        wexp[i] = wexp[i] + 16'd1;
    endtask

    task automatic wait_done(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            if (rq[i].size() == 0 && !ld_pend[i] && !busy[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            txq[i].delete(); exq[i].delete(); rcyc[i].delete(); wcyc[i].delete();
        end
    endtask

    // -1 when captured stream equals expected, else first differing index
    function automatic int first_diff(input int i);
        int n;
        n = (txq[i].size() < exq[i].size()) ? txq[i].size() : exq[i].size();
        for (int k = 0; k < n; k++) if (txq[i][k] !== exq[i][k]) return k;
        if (txq[i].size() != exq[i].size()) return n;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({rd_en[i], wr_en[i], busy[i], din[i], wcnt[i]} !== 27'd0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got rd=%b wr=%b busy=%b din=%h cnt=%h want all 0",
                         i, rd_en[i], wr_en[i], busy[i], din[i], wcnt[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int rc;
        clear_logs();
        rc = rd_cnt[0];
        push_word(0, 32'h0123ABCF);
        wait_done(0, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout: got busy want idle"); end
        total++;
        if (first_diff(0) != -1) begin
            bad++;
            $display("FAIL basic_stream: got %0d bytes want %0d, first diff at %0d", txq[0].size(), exq[0].size(), first_diff(0));
        end
        total++;
        if (rd_cnt[0] - rc != 1) begin bad++; $display("FAIL basic_rd_pulses: got %0d want 1", rd_cnt[0] - rc); end
        total++;
        if (wcnt[0] !== wexp[0]) begin bad++; $display("FAIL basic_word_cnt: got %h want %h", wcnt[0], wexp[0]); end
        total++;
        if (rcyc[0].size() != 1 || wcyc[0].size() != 10 ||
            wcyc[0][0] - rcyc[0][0] != 2 || wcyc[0][9] - wcyc[0][0] != 9) begin
            bad++;
            $display("FAIL basic_latency: got pops=%0d writes=%0d want pop->first=2 first->last=9",
                     rcyc[0].size(), wcyc[0].size());
        end
    endtask

    task automatic test_lowercase_noeol();
        bit ok1, ok2;
        clear_logs();
        push_word(1, 32'hDEADBEEF);
        push_word(2, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            push_word(1, $urandom);
            push_word(2, $urandom);
        end
        wait_done(1, 400, ok1);
        wait_done(2, 400, ok2);
        for (int i = 1; i < 3; i++) begin
            total++;
            if (first_diff(i) != -1) begin
                bad++;
                $display("FAIL param_stream[%0d]: got %0d bytes want %0d, first diff at %0d",
                         i, txq[i].size(), exq[i].size(), first_diff(i));
            end
            total++;
            if (wcnt[i] !== wexp[i]) begin bad++; $display("FAIL param_word_cnt[%0d]: got %h want %h", i, wcnt[i], wexp[i]); end
        end
        total++;
        if (!(ok1 && ok2) || txq[2].size() != 40) begin
            bad++;
            $display("FAIL noeol_bytes: got %0d want 40", txq[2].size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        int nbad;
        clear_logs();
        push_word(0, 32'hFFFFFFFF);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (txq[0].size() >= 2) break;
        end
        full[0] = 1'b1;
        nbad = 0;
        repeat (5) begin
            #1;
            if (wr_en[0] !== 1'b0 || din[0] !== 8'h46) nbad++;
            @(posedge clk); #1;
        end
        full[0] = 1'b0;
        total++;
        if (nbad != 0) begin bad++; $display("FAIL stall_hex_hold: got %0d bad cycles want 0", nbad); end
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (txq[0].size() >= 8) break;
        end
        full[0] = 1'b1;
        nbad = 0;
        repeat (3) begin
            #1;
            if (wr_en[0] !== 1'b0 || din[0] !== 8'h0D) nbad++;
            @(posedge clk); #1;
        end
        full[0] = 1'b0;
        total++;
        if (nbad != 0) begin bad++; $display("FAIL stall_cr_hold: got %0d bad cycles want 0", nbad); end
        wait_done(0, 100, ok);
        total++;
        if (!ok || first_diff(0) != -1) begin
            bad++;
            $display("FAIL stall_stream: got %0d bytes want %0d", txq[0].size(), exq[0].size());
        end

        // random back-pressure on two instances at once
        clear_logs();
        for (int k = 0; k < 6; k++) begin
            push_word(0, $urandom);
            push_word(1, $urandom);
        end
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (rq[0].size() == 0 && rq[1].size() == 0 && !ld_pend[0] && !ld_pend[1] &&
                !busy[0] && !busy[1]) begin
                ok = 1'b1;
                break;
            end
            full[0] = ($urandom_range(0, 2) == 0);
            full[1] = ($urandom_range(0, 2) == 0);
        end
        full[0] = 1'b0;
        full[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (!ok || first_diff(i) != -1) begin
                bad++;
                $display("FAIL rand_stall_stream[%0d]: got %0d bytes want %0d, diff at %0d",
                         i, txq[i].size(), exq[i].size(), first_diff(i));
            end
            total++;
            if (wcnt[i] !== wexp[i]) begin bad++; $display("FAIL rand_stall_cnt[%0d]: got %h want %h", i, wcnt[i], wexp[i]); end
        end
        total++;
        if (viol[0] + viol[1] != 0) begin bad++; $display("FAIL stall_protocol: got %0d violations want 0", viol[0] + viol[1]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit seen;
        int lows, rc;
        clear_logs();
        rc   = rd_cnt[0];
        seen = 1'b0;
        lows = 0;
        push_word(0, 32'h00000000);
        push_word(0, 32'h89ABCDEF);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (txq[0].size() >= 20) break;
            if (busy[0]) seen = 1'b1;
            else if (seen) lows++;
        end
        wait_done(0, 100, ok);
        total++;
        if (!ok || first_diff(0) != -1) begin
            bad++;
            $display("FAIL b2b_stream: got %0d bytes want %0d", txq[0].size(), exq[0].size());
        end
        total++;
        if (rd_cnt[0] - rc != 2) begin bad++; $display("FAIL b2b_rd_pulses: got %0d want 2", rd_cnt[0] - rc); end
        total++;
        if (wcnt[0] !== wexp[0]) begin bad++; $display("FAIL b2b_word_cnt: got %h want %h", wcnt[0], wexp[0]); end
        total++;
        if (lows != 1) begin bad++; $display("FAIL b2b_busy_gap: got %0d want 1", lows); end
        total++;
        if (rcyc[0].size() != 2 || wcyc[0].size() != 20 || rcyc[0][1] - wcyc[0][9] != 2) begin
            bad++;
            $display("FAIL b2b_pop_spacing: got pops=%0d writes=%0d want pop 2 cycles after LF",
                     rcyc[0].size(), wcyc[0].size());
        end
        total++;
        if (viol[0] != 0) begin bad++; $display("FAIL b2b_protocol: got %0d violations want 0", viol[0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int pre;
        clear_logs();
        push_word(0, 32'h12345678);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (txq[0].size() >= 4) break;
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({rd_en[0], wr_en[0], busy[0], din[0], wcnt[0]} !== 27'd0) begin
            bad++;
            $display("FAIL midreset_async: got rd=%b wr=%b busy=%b din=%h cnt=%h want all 0",
                     rd_en[0], wr_en[0], busy[0], din[0], wcnt[0]);
        end
        pre = 0;
        for (int k = 0; k < 4; k++) if (txq[0].size() > k && txq[0][k] === exq[0][k]) pre++;
        total++;
        if (txq[0].size() != 4 || pre != 4) begin
            bad++;
            $display("FAIL midreset_prefix: got %0d bytes (%0d matching) want 4", txq[0].size(), pre);
        end
        @(posedge clk); @(negedge clk); @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            rq[i].delete();
            ld_pend[i] = 1'b0;
            wexp[i]    = '0;
        end
        clear_logs();
        rst = 1'b0;
        push_word(0, 32'h0000000A);
        wait_done(0, 100, ok);
        total++;
        if (!ok || first_diff(0) != -1) begin
            bad++;
            $display("FAIL midreset_next_word: got %0d bytes want %0d, diff at %0d",
                     txq[0].size(), exq[0].size(), first_diff(0));
        end
        total++;
        if (wcnt[0] !== 16'h0001) begin bad++; $display("FAIL midreset_cnt: got %h want 0001", wcnt[0]); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        force u_ne.word_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release u_ne.word_cnt;
        push_word(2, $urandom);
        wait_done(2, 100, ok);
        total++;
        if (!ok || wcnt[2] !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff: got %h want ffff", wcnt[2]); end
        push_word(2, $urandom);
        wait_done(2, 100, ok);
        total++;
        if (!ok || wcnt[2] !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", wcnt[2]); end
        total++;
        if (txq[2].size() != 16 || first_diff(2) != -1) begin
            bad++;
            $display("FAIL wrap_stream: got %0d bytes want 16", txq[2].size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lowercase_noeol();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        total++;
        if (viol[0] + viol[1] + viol[2] != 0) begin
            bad++;
            $display("FAIL protocol_total: got %0d violations want 0", viol[0] + viol[1] + viol[2]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
